// File: rtl/regfile_dump_reader_pkg.sv
// Shared definitions for the register-bank dump reader.
//   REG_ADDR_W / REG_DATA_W : geometry of the 32x32 register bank, shared
//                             with the bank itself so both agree.
//   dump_state_t / ST_*     : dump reader FSM encoding.
package regfile_dump_reader_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;

    typedef logic [1:0] dump_state_t;

    localparam dump_state_t ST_IDLE = 2'd0;
    localparam dump_state_t ST_READ = 2'd1;
    localparam dump_state_t ST_SEND = 2'd2;
    localparam dump_state_t ST_FIN  = 2'd3;

endpackage

// File: rtl/regfile_dump_reader.sv
// Sequential debug reader on a spare read port of the register bank.
// On start it walks addresses FIRST_REG..LAST_REG, drives each one onto the
// bank read port, captures the returned word and presents (address, data)
// records on a valid/ready stream. Each register costs one READ cycle and at
// least one SEND cycle.
//
// Ports:
//   clock     : system clock, rising edge active
//   reset     : asynchronous active-high reset
//   start     : dump request, honoured only while idle
//   abort     : synchronous cancel of a dump in progress
//   rd_addr   : address to the bank read port (combinational from idx)
//   rd_data   : combinational read data from the bank
//   out_valid : record valid
//   out_ready : consumer accepts the record
//   out_addr  : address of the current record
//   out_data  : value of the current record
//   busy      : high while a dump is in progress
//   done      : one-cycle pulse after the last record is accepted
module regfile_dump_reader
    import regfile_dump_reader_pkg::*;
#(
    parameter int DATA_W    = REG_DATA_W,
    parameter int ADDR_W    = REG_ADDR_W,
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(FIRST_REG);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST_REG);

    dump_state_t       state;
    logic [ADDR_W-1:0] idx;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            idx      <= FIRST_A;
            out_addr <= '0;
            out_data <= '0;
        end else if (abort && (state != ST_IDLE)) begin
            // Cancel wins over any handshake in the same cycle; the
            // consumer sees the record as taken only if it was ready.
            state <= ST_IDLE;
            idx   <= FIRST_A;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        idx   <= FIRST_A;
                        state <= ST_READ;
                    end
                end
                ST_READ: begin
                    // rd_data reflects the bank before any write landing on
                    // this same edge.
                    out_data <= rd_data;
                    out_addr <= idx;
                    state    <= ST_SEND;
                end
                ST_SEND: begin
                    if (out_ready) begin
                        if (idx == LAST_A) begin
                            state <= ST_FIN;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= ST_READ;
                        end
                    end
                end
                default: begin
                    idx   <= FIRST_A;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rd_addr   = idx;
    // Valid is a pure state decode, so there is no ready-to-valid path.
    assign out_valid = (state == ST_SEND);
    assign busy      = (state != ST_IDLE);
    // An abort landing in FIN suppresses the pulse.
    assign done      = (state == ST_FIN) && !abort;

endmodule

// File: tb/tb_regfile_dump_reader.sv
module tb_regfile_dump_reader;

    logic        clock;
    logic        reset;
    logic        start;
    logic        start2;
    logic        abort;
    logic        out_ready;

    logic [4:0]  m_rd_addr;
    logic [31:0] m_rd_data;
    logic        m_valid;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic        m_busy;
    logic        m_done;

    logic [4:0]  s_rd_addr;
    logic [31:0] s_rd_data;
    logic        s_valid;
    logic [4:0]  s_addr;
    logic [31:0] s_data;
    logic        s_busy;
    logic        s_done;

    logic [31:0] bank [32];
    logic        pend_wr;

    int total = 0;
    int bad   = 0;

    assign m_rd_data = bank[m_rd_addr];
    assign s_rd_data = bank[s_rd_addr];

    regfile_dump_reader u_dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .rd_addr  (m_rd_addr),
        .rd_data  (m_rd_data),
        .out_valid(m_valid),
        .out_ready(out_ready),
        .out_addr (m_addr),
        .out_data (m_data),
        .busy     (m_busy),
        .done     (m_done)
    );

    regfile_dump_reader #(.FIRST_REG(4), .LAST_REG(6)) u_sub (
        .clock    (clock),
        .reset    (reset),
        .start    (start2),
        .abort    (abort),
        .rd_addr  (s_rd_addr),
        .rd_data  (s_rd_data),
        .out_valid(s_valid),
        .out_ready(out_ready),
        .out_addr (s_addr),
        .out_data (s_data),
        .busy     (s_busy),
        .done     (s_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance one clock; a pending bank write lands on that same edge.
    task automatic cycle();
        @(posedge clock);
        if (pend_wr) begin
            bank[10] <= 32'hDEADBEEF;
            pend_wr = 1'b0;
        end
        #1;
    endtask

    // mode 0: ready always, 1: stall 5 cycles at addr 7, 2: random ready,
    // 3: bank write to reg 10 on its capture edge, 4: extra start at addr 3.
    task automatic run_dump(input int mode);
        logic [31:0] exp_d [32];
        int   k, n, dones, hold, exp_n;
        logic pv, pr, restarted;
        logic [4:0]  pa;
        logic [31:0] pd;
        for (int i = 0; i < 32; i++) exp_d[i] = bank[5'(i)];
        k = 0; n = 1; dones = 0; hold = 0;
        pv = 1'b0; pr = 1'b1; pa = '0; pd = '0; restarted = 1'b0;
        exp_n = (mode == 1) ? 70 : 65;
        start = 1'b1;
        cycle();
        start = 1'b0;
        check("lat_busy", 32'(m_busy), 32'd1);
        check("lat_read_valid", 32'(m_valid), 32'd0);
        while (n < 3000 && dones == 0) begin
            case (mode)
                1: begin
                    if (m_valid && m_addr == 5'd7 && hold < 5) begin
                        out_ready = 1'b0;
                        hold++;
                    end else out_ready = 1'b1;
                end
                2: out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b1;
            endcase
            if (n == 2) check("lat_send_valid", 32'(m_valid), 32'd1);
            if (pv && !pr) begin
                check("hold_valid", 32'(m_valid), 32'd1);
                check("hold_addr", 32'(m_addr), 32'(pa));
                check("hold_data", m_data, pd);
            end
            if (m_valid && out_ready) begin
                if (k < 32) begin
                    check("rec_addr", 32'(m_addr), 32'(k));
                    check("rec_data", m_data, exp_d[5'(k)]);
                end else begin
                    check("extra_rec", 32'(k), 32'd31);
                end
                k++;
            end
            if (mode == 3 && m_busy && !m_valid && m_rd_addr == 5'd10) pend_wr = 1'b1;
            if (mode == 4) begin
                start = 1'b0;
                if (!restarted && m_busy && !m_valid && m_rd_addr == 5'd3) begin
                    start = 1'b1;
                    restarted = 1'b1;
                end
            end
            if (m_done) begin
                dones++;
                check("done_records", 32'(k), 32'd32);
                if (mode != 2) check("done_cycle", 32'(n), 32'(exp_n));
            end
            pv = m_valid; pr = out_ready; pa = m_addr; pd = m_data;
            cycle();
            n++;
        end
        start = 1'b0;
        out_ready = 1'b1;
        if (dones == 0) check("timeout_done", 32'd0, 32'd1);
        check("post_busy", 32'(m_busy), 32'd0);
        check("post_done", 32'(m_done), 32'd0);
        for (int j = 0; j < 4; j++) begin
            cycle();
            check("post_idle_valid", 32'(m_valid), 32'd0);
        end
    endtask

    initial begin
        int k, t;
        reset = 1'b1; start = 1'b0; start2 = 1'b0; abort = 1'b0;
        out_ready = 1'b1; pend_wr = 1'b0;
        for (int i = 0; i < 32; i++) bank[i] = i * 32'h01010101;
        #12;
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_busy", 32'(m_busy), 32'd0);
        check("rst_done", 32'(m_done), 32'd0);
        check("rst_rd_addr", 32'(m_rd_addr), 32'd0);
        check("rst_out_addr", 32'(m_addr), 32'd0);
        check("rst_out_data", m_data, 32'd0);
        check("rst_sub_rd_addr", 32'(s_rd_addr), 32'd4);
        reset = 1'b0;
        cycle();

        // Start with abort held is ignored.
        start = 1'b1; abort = 1'b1;
        cycle();
        start = 1'b0; abort = 1'b0;
        check("start_abort_ignored", 32'(m_busy), 32'd0);

        run_dump(0);
        run_dump(1);
        run_dump(3);
        check("bank10_written", bank[10], 32'hDEADBEEF);
        run_dump(0);
        bank[10] = 32'h0A0A0A0A;
        run_dump(4);

        // Abort at address 12 with the consumer stalled.
        start = 1'b1;
        cycle();
        start = 1'b0;
        t = 0;
        while (t < 200 && !(m_valid && m_addr == 5'd12)) begin
            cycle();
            t++;
        end
        if (t >= 200) check("timeout_abort", 32'd0, 32'd1);
        out_ready = 1'b0; abort = 1'b1;
        check("abort_cycle_done", 32'(m_done), 32'd0);
        cycle();
        abort = 1'b0; out_ready = 1'b1;
        check("abort_valid", 32'(m_valid), 32'd0);
        check("abort_busy", 32'(m_busy), 32'd0);
        check("abort_rd_addr", 32'(m_rd_addr), 32'd0);
        for (int j = 0; j < 3; j++) begin
            cycle();
            check("abort_no_done", 32'(m_done), 32'd0);
        end
        run_dump(0);

        // Short range instance: records 4, 5, 6 then done.
        start2 = 1'b1;
        cycle();
        start2 = 1'b0;
        k = 0; t = 0;
        while (t < 100 && !s_done) begin
            if (s_valid) begin
                check("sub_addr", 32'(s_addr), 32'(4 + k));
                check("sub_data", s_data, bank[5'(4 + k)]);
                k++;
            end
            cycle();
            t++;
        end
        if (t >= 100) check("timeout_sub", 32'd0, 32'd1);
        check("sub_count", 32'(k), 32'd3);
        cycle();
        check("sub_busy_after", 32'(s_busy), 32'd0);

        // Asynchronous reset in the middle of a SEND cycle.
        start = 1'b1;
        cycle();
        start = 1'b0;
        t = 0;
        while (t < 20 && !m_valid) begin
            cycle();
            t++;
        end
        if (t >= 20) check("timeout_areset", 32'd0, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("areset_valid", 32'(m_valid), 32'd0);
        check("areset_busy", 32'(m_busy), 32'd0);
        check("areset_done", 32'(m_done), 32'd0);
        check("areset_out_data", m_data, 32'd0);
        check("areset_rd_addr", 32'(m_rd_addr), 32'd0);
        #3;
        reset = 1'b0;
        cycle();
        cycle();
        check("areset_idle", 32'(m_busy), 32'd0);

        // Random bank contents with random backpressure.
        for (int i = 1; i < 32; i++) bank[i] = $urandom;
        run_dump(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
